mdu_div_core: RTL and testbench
===============================

# mdu_div_core

Iterative 32-bit restoring divider for the execute-stage multiply/divide unit. The MDU's operand path feeds it; its quotient and remainder are written to LO and HI respectively. It handles both DIV (signed) and DIVU (unsigned) in a fixed number of cycles. It also supports cancellation when an interrupt or exception request kills the in-flight instruction.

## Interface
Parameters:
- `STEPS`, 32: quotient bits produced; one bit per cycle.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; returns block to IDLE.
- `start`  in  1  request a division; sampled only in IDLE.
- `isSigned`  in  1  1 = DIV semantics, 0 = DIVU; sampled with `start`.
- `dividend`  in  32  numerator; sampled with `start`.
- `divisor`  in  32  denominator; sampled with `start`.
- `cancel`  in  1  kill current operation (exception/interrupt request).
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; results valid and updated.
- `quotient`  out  32  result for LO.
- `remainder`  out  32  result for HI.
- `divByZero`  out  1  high with `done` when divisor was 0; held until next `done`.

## Operation
- States: IDLE, CALC, FIX.
- IDLE with `start`=1 and `cancel`=0:
  - Latch the magnitudes of the operands. Magnitude is the absolute value when `isSigned`; otherwise the raw value.
  - Latch the sign of the dividend, the sign of the quotient, and the zero-divisor flag.
  - Clear the partial remainder.
  - Load step counter with `STEPS`; go to CALC.
- CALC: one restoring step per edge.
  - Shift {partial remainder, dividend-magnitude} left by 1.
  - Trial-subtract the divisor magnitude from the 33-bit partial remainder.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter. The edge that retires the last step moves to FIX.
- FIX: apply signs, then update `quotient`, `remainder` and `divByZero`, pulse `done`, and go to IDLE.
  - Quotient is negated iff `isSigned` and the operand signs differ.
  - Remainder takes the dividend's sign (truncating division, identical to Verilog `$signed /` and `%`).
  - Divide-by-zero: `quotient`=32'hFFFFFFFF and `remainder`=original `dividend`, with no sign fix for either signedness. `divByZero` is set to 1.
  - Signed overflow 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0; there is no special case.
- `start` outside IDLE: ignored. The upstream stall logic guarantees it is not issued.
- `cancel`=1 in any state:
  - Next state is IDLE, and `done` is not pulsed.
  - `quotient`, `remainder` and `divByZero` keep their previous values.
  - `cancel` beats `start` in the same cycle.
- `reset`=1: beats everything.
  - State goes to IDLE, and the counter and internal registers go to 0.
  - Outputs: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `divByZero`=0.

## Timing
- `busy` is registered, equal to (state != IDLE). It is 0 in the `start` cycle.
  - The MDU ORs its own combinational start term to form the stall signal.
- Let the edge sampling `start` be edge E0.
  - E0 enters CALC.
  - E1..E32 perform the steps; edge E32 enters FIX.
  - E33 writes results.
- `done`=1 and results are valid in the cycle after E33. That is 34 cycles after the `start` cycle, with `busy`=0 in that cycle.
- `busy` is high for exactly 33 cycles per uncancelled operation.
- A new `start` is accepted in the `done` cycle, giving back-to-back operations with a 34-cycle period.
- `cancel` asserted in a cycle leaves `busy`=0 on the next cycle, and a new `start` is accepted there.
- Results change only on the E33 edge. They are stable at all other times, so the MDU may sample them on `done`.

## Structure
- Shared package `mdu_pkg`:
  - State encoding constants IDLE/CALC/FIX.
  - `STEPS` default (32) and the counter width (6 bits).
  - The divide-by-zero quotient constant 32'hFFFFFFFF.
- Sub-module `div_step`: purely combinational single restoring step.
  - Inputs: 33-bit partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new partial remainder and quotient bit.
  - `mdu_div_core` instantiates it once and holds all sequential state.

## Test plan
- Unsigned: DIVU 100 / 7 -> `done` 34 cycles after `start`, `quotient`=14, `remainder`=2, `divByZero`=0. `busy` high for 33 cycles.
- Signed sign rules:
  - DIV -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
  - DIV 7 / -2 -> quotient -3, remainder 1.
- Edge values:
  - DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
  - DIVU 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- Divide-by-zero: DIV 0x12345678 / 0 -> quotient 0xFFFFFFFF, remainder 0x12345678, `divByZero`=1 with `done`.
- Cancel/reset mid-run:
  - `start` DIVU 50/5, then `cancel` at cycle 10 -> `busy`=0 next cycle, no `done`, outputs keep prior values. A new DIVU 9/4 started the next cycle yields 2, 1.
  - `reset` at cycle 20 of an operation -> all outputs 0, IDLE.
- Back-to-back: `start` DIVU 20/3 asserted in the `done` cycle of a prior operation -> accepted. 34 cycles later: quotient 6, remainder 2.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit's divider path.
// Contents: divider state encoding, default step count and counter width,
// the quotient value reported on divide-by-zero, and an operand
// magnitude helper used when DIV operands are latched.
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = 6;

    localparam logic [31:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

    // Absolute value for signed operands, raw value for unsigned ones.
    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] value,
                                              input logic        is_signed);
        return (is_signed && value[31]) ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/mdu_div_core_if.sv
// Handshake/data bundle between the MDU control logic and the divider.
//   master (MDU):     drives start, isSigned, dividend, divisor, cancel;
//                     receives busy, done, quotient, remainder, divByZero.
//   slave  (divider): the mirror image.
interface mdu_div_core_if;

    logic        start;
    logic        isSigned;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        divByZero;

    modport master (
        output start, isSigned, dividend, divisor, cancel,
        input  busy, done, quotient, remainder, divByZero
    );

    modport slave (
        input  start, isSigned, dividend, divisor, cancel,
        output busy, done, quotient, remainder, divByZero
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_in   33-bit partial remainder before the step
//   dvd_bit  next dividend bit shifted into the remainder
//   dvs      divisor magnitude
//   rem_out  partial remainder after the step (restored when the trial fails)
//   q_bit    quotient bit produced by this step
module div_step (
    input  logic [32:0] rem_in,
    input  logic        dvd_bit,
    input  logic [31:0] dvs,
    output logic [32:0] rem_out,
    output logic        q_bit
);

    logic [33:0] shifted;
    logic [33:0] trial;

    // One extra bit of headroom so the sign of the trial subtraction is
    // visible even when the shifted remainder uses all 33 bits.
    assign shifted = {rem_in, dvd_bit};
    assign trial   = shifted - {2'b00, dvs};

    assign q_bit   = ~trial[33];
    assign rem_out = trial[33] ? shifted[32:0] : trial[32:0];

endmodule

// File: rtl/mdu_div_core.sv
// Iterative 32-bit restoring divider (DIV / DIVU) for the MDU.
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  synchronous active-high reset, returns to IDLE with outputs 0
//   div    mdu_div_core_if.slave: start/isSigned/dividend/divisor/cancel in,
//          busy/done/quotient/remainder/divByZero out
// A started operation takes one edge to load, STEPS edges to compute and
// one edge to apply signs, so done appears 34 cycles after start.
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int STEPS = DIV_STEPS
) (
    input  logic            clk,
    input  logic            reset,
    mdu_div_core_if.slave   div
);

    div_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [32:0]       rem_reg;
    logic [31:0]       dvd_reg;      // dividend magnitude, becomes quotient
    logic [31:0]       dvs_reg;
    logic [31:0]       orig_dvd_reg; // raw dividend for the divide-by-zero result
    logic              neg_q_reg;
    logic              neg_r_reg;
    logic              dbz_reg;

    logic              busy_reg;
    logic              done_reg;
    logic [31:0]       quotient_reg;
    logic [31:0]       remainder_reg;
    logic              div_by_zero_reg;

    logic              accept;
    logic              step_en;
    logic              fix_en;

    logic [32:0]       step_rem;
    logic              step_qbit;

    div_step u_step (
        .rem_in  (rem_reg),
        .dvd_bit (dvd_reg[31]),
        .dvs     (dvs_reg),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    // Next-state and datapath enables; cancel overrides every transition
    // and suppresses every datapath update, including the result write.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        step_en    = 1'b0;
        fix_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (div.start) begin
                    state_next = CALC;
                    accept     = 1'b1;
                end
            end
            CALC: begin
                step_en = 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                fix_en     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (div.cancel) begin
            state_next = IDLE;
            accept     = 1'b0;
            step_en    = 1'b0;
            fix_en     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg         <= '0;
            rem_reg         <= '0;
            dvd_reg         <= '0;
            dvs_reg         <= '0;
            orig_dvd_reg    <= '0;
            neg_q_reg       <= 1'b0;
            neg_r_reg       <= 1'b0;
            dbz_reg         <= 1'b0;
            done_reg        <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            div_by_zero_reg <= 1'b0;
        end else begin
            done_reg <= fix_en;
            if (accept) begin
                cnt_reg      <= CNT_W'(STEPS);
                rem_reg      <= '0;
                dvd_reg      <= magnitude(div.dividend, div.isSigned);
                dvs_reg      <= magnitude(div.divisor, div.isSigned);
                orig_dvd_reg <= div.dividend;
                neg_q_reg    <= div.isSigned & (div.dividend[31] ^ div.divisor[31]);
                neg_r_reg    <= div.isSigned & div.dividend[31];
                dbz_reg      <= (div.divisor == 32'd0);
            end
            if (step_en) begin
                // Dividend shifts out of the top while quotient bits fill
                // in from the bottom, so dvd_reg ends up holding |quotient|.
                rem_reg <= step_rem;
                dvd_reg <= {dvd_reg[30:0], step_qbit};
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
            if (fix_en) begin
                div_by_zero_reg <= dbz_reg;
                if (dbz_reg) begin
                    quotient_reg  <= DBZ_QUOTIENT;
                    remainder_reg <= orig_dvd_reg;
                end else begin
                    quotient_reg  <= neg_q_reg ? (~dvd_reg + 32'd1) : dvd_reg;
                    remainder_reg <= neg_r_reg ? (~rem_reg[31:0] + 32'd1) : rem_reg[31:0];
                end
            end
        end
    end

    assign div.busy      = busy_reg;
    assign div.done      = done_reg;
    assign div.quotient  = quotient_reg;
    assign div.remainder = remainder_reg;
    assign div.divByZero = div_by_zero_reg;

endmodule

// File: tb/tb_mdu_div_core.sv
// Self-checking bench for mdu_div_core: directed cases, cancel/reset
// mid-run, back-to-back starts and randomized DIV/DIVU traffic, with a
// queue-based scoreboard drained by a monitor on every done pulse.
module tb_mdu_div_core;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    logic clk;
    logic reset;

    mdu_div_core_if div_if ();

    mdu_div_core #(.STEPS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .div   (div_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          unstable = 0;
    exp_t        last_exp;
    logic [64:0] prev_out;
    logic        reset_seen;

    // Reference: truncating division from plain arithmetic on wide ints,
    // with the architectural divide-by-zero result.
    function automatic exp_t model(input bit s, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb_;
        longint q64;
        longint r64;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.z = 1'b1;
        end else if (s) begin
            sa  = longint'($signed(a));
            sb_ = longint'($signed(b));
            q64 = sa / sb_;
            r64 = sa % sb_;
            e.q = q64[31:0];
            e.r = r64[31:0];
            e.z = 1'b0;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse pops one expected response.
    always @(negedge clk) begin
        if (div_if.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: q=%h r=%h z=%b with empty scoreboard",
                         div_if.quotient, div_if.remainder, div_if.divByZero);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check32("quotient", div_if.quotient, e.q);
                check32("remainder", div_if.remainder, e.r);
                check32("divByZero", {31'd0, div_if.divByZero}, {31'd0, e.z});
                $display("done: q=%h r=%h z=%b", div_if.quotient, div_if.remainder, div_if.divByZero);
            end
        end
    end

    // Results may only move on a done pulse or because of reset.
    always @(negedge clk) begin
        logic [64:0] cur;
        cur = {div_if.quotient, div_if.remainder, div_if.divByZero};
        if (div_if.done !== 1'b1 && !reset_seen && cur !== prev_out) unstable++;
        prev_out   = cur;
        reset_seen = reset;
    end

    // Called #1 after a rising edge; issues start in the current cycle and
    // returns #1 after the edge that produces done (the done cycle).
    task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   cyc;
        int   busy_cnt;
        e = model(s, a, b);
        sb.push_back(e);
        last_exp = e;
        $display("start: %s a=%h b=%h expect q=%h r=%h z=%b",
                 s ? "DIV " : "DIVU", a, b, e.q, e.r, e.z);
        check32("busy_in_start_cycle", {31'd0, div_if.busy}, 32'd0);
        div_if.start    = 1'b1;
        div_if.isSigned = s;
        div_if.dividend = a;
        div_if.divisor  = b;
        cyc      = 0;
        busy_cnt = 0;
        do begin
            @(posedge clk);
            #1;
            div_if.start = 1'b0;
            cyc++;
            if (div_if.busy === 1'b1) busy_cnt++;
        end while (div_if.done !== 1'b1 && cyc < 60);
        check32("done_latency", cyc, 34);
        check32("busy_cycles", busy_cnt, 33);
    endtask

    task automatic issue_only(input logic [31:0] a, input logic [31:0] b);
        div_if.start    = 1'b1;
        div_if.isSigned = 1'b0;
        div_if.dividend = a;
        div_if.divisor  = b;
        @(posedge clk);
        #1;
        div_if.start = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        int          sel;

        reset           = 1'b1;
        div_if.start    = 1'b0;
        div_if.isSigned = 1'b0;
        div_if.dividend = '0;
        div_if.divisor  = '0;
        div_if.cancel   = 1'b0;
        prev_out        = '0;
        reset_seen      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check32("reset_busy", {31'd0, div_if.busy}, 32'd0);
        check32("reset_done", {31'd0, div_if.done}, 32'd0);
        check32("reset_quotient", div_if.quotient, 32'd0);
        check32("reset_remainder", div_if.remainder, 32'd0);
        check32("reset_divByZero", {31'd0, div_if.divByZero}, 32'd0);

        // Directed cases, each started in the done cycle of the previous.
        run_op(1'b0, 32'd100, 32'd7);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1);
        run_op(1'b1, 32'h1234_5678, 32'd0);
        run_op(1'b0, 32'd20, 32'd3);

        // Cancel ten cycles into DIVU 50/5.
        @(posedge clk);
        #1;
        issue_only(32'd50, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        div_if.cancel = 1'b1;
        @(posedge clk);
        #1;
        div_if.cancel = 1'b0;
        check32("cancel_busy", {31'd0, div_if.busy}, 32'd0);
        check32("cancel_done", {31'd0, div_if.done}, 32'd0);
        check32("cancel_keep_q", div_if.quotient, last_exp.q);
        check32("cancel_keep_r", div_if.remainder, last_exp.r);
        check32("cancel_keep_z", {31'd0, div_if.divByZero}, {31'd0, last_exp.z});
        run_op(1'b0, 32'd9, 32'd4);

        // Cancel in the same cycle as start: must not be accepted.
        @(posedge clk);
        #1;
        div_if.cancel = 1'b1;
        issue_only(32'd77, 32'd3);
        div_if.cancel = 1'b0;
        check32("cancel_beats_start", {31'd0, div_if.busy}, 32'd0);

        // Reset twenty cycles into an operation.
        issue_only(32'd1000, 32'd9);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check32("midreset_busy", {31'd0, div_if.busy}, 32'd0);
        check32("midreset_quotient", div_if.quotient, 32'd0);
        check32("midreset_remainder", div_if.remainder, 32'd0);
        check32("midreset_divByZero", {31'd0, div_if.divByZero}, 32'd0);

        // Randomized back-to-back traffic.
        for (int i = 0; i < 40; i++) begin
            s   = 1'($urandom_range(0, 1));
            a   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                3:       begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(s, a, b);
        end

        repeat (3) @(posedge clk);
        #1;
        check32("scoreboard_empty", sb.size(), 32'd0);
        check32("results_stable", unstable, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
